// File: rtl/rr_arbiter4_pkg.sv
// Shared types, sizes and the rotate helper for the 4-way round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  // Two-state grant FSM: nobody holds the resource, or exactly one requester does.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Rotate right: result bit j is v[(j + sh) mod NUM_REQ], so the requester
  // at index sh lands on bit 0 and becomes the highest-priority candidate.
  function automatic logic [NUM_REQ-1:0] rotate_right(input logic [NUM_REQ-1:0] v,
                                                      input logic [ID_W-1:0]    sh);
    return NUM_REQ'({v, v} >> sh);
  endfunction

endpackage : rr_arbiter4_pkg

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches the masked request vector
// starting at the requester after ptr and returns the first one found.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W-1:0]    start;
  logic [NUM_REQ-1:0] rotated;
  logic [ID_W-1:0]    offset;

  // The search begins one past the last grantee; 2-bit arithmetic wraps 3 -> 0.
  assign start   = ptr + ID_W'(1);
  assign rotated = rotate_right(req & ~excl, start);
  assign any     = |rotated;

  // Priority-encode the rotated vector, lowest index wins.
  // NOTE: offset gets a default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    offset = '0;
    if (rotated[0])      offset = 2'd0;
    else if (rotated[1]) offset = 2'd1;
    else if (rotated[2]) offset = 2'd2;
    else if (rotated[3]) offset = 2'd3;
  end

  // Undo the rotation to recover the absolute requester index.
  assign id = offset + start;

endmodule : rr_pick4

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// grant holding while the holder keeps requesting, and a fairness timeout.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic [7:0]         hold_cnt
);

  localparam logic [7:0] HOLD_LIM   = 8'(MAX_HOLD);
  localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [7:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic [NUM_REQ-1:0] excl;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic               holder_req;
  logic               timeout;

  // While granting, the holder is masked out so a timeout re-arbitration
  // cannot hand the grant straight back to it. When it has released, its
  // bit is already low and the mask changes nothing.
  assign excl = (state_q == ST_GRANT) ? (NUM_REQ'(1) << id_q) : '0;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .excl (excl),
    .id   (pick_id),
    .any  (pick_any)
  );

  assign holder_req = req[id_q];
  assign timeout    = TIMEOUT_EN && (hold_q == HOLD_LIM);

  // Next-state logic: grant, hold, hand over on release/timeout, or go idle.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          id_d    = pick_id;
          ptr_d   = pick_id;
          hold_d  = 8'd1;
        end
      end

      ST_GRANT: begin
        if (!holder_req || timeout) begin
          // Release or fairness timeout: hand over with no idle gap if
          // anyone else is waiting.
          if (pick_any) begin
            id_d   = pick_id;
            ptr_d  = pick_id;
            hold_d = 8'd1;
          end else if (!holder_req) begin
            state_d = ST_IDLE;
            id_d    = '0;
            hold_d  = '0;
          end
          // Timeout with nobody else waiting: keep the grant, and hold_cnt
          // stays parked at MAX_HOLD.
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        id_d    = '0;
        hold_d  = '0;
      end
    endcase
  end

  // The one-hot grant is decoded from the next id so it can be registered.
  assign gnt_d = (state_d == ST_GRANT) ? (NUM_REQ'(1) << id_d) : '0;

  // State register with synchronous active-low reset; ptr resets to the last
  // requester so the first search starts at requester 0.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == ST_GRANT);
  assign hold_cnt  = hold_q;

endmodule : rr_arbiter4
